mac_tx_arbiter: RTL and testbench
=================================

Name: mac_tx_arbiter

Overview:
- Sits directly upstream of the MAC transmit framer.
- Arbitrates between two payload sources, ARP (source 0) and IP (source 1), and streams one granted payload at a time into the framer's send interface.
- Supplies the EtherType and payload length with the payload.
- Enforces a post-frame hold-off so a new payload never enters the framer before it has finished emitting header, CRC and inter-frame gap.

Parameters:
- P_ARP_TYPE, 16'h0806, EtherType driven for source 0.
- P_IP_TYPE, 16'h0800, EtherType driven for source 1.
- P_GAP_CYCLES, 48, idle cycles after the last forwarded byte before the next grant; covers 22 B preamble/header, 4 B CRC, 12 B IFG and pipeline.
- P_GRANT_TIMEOUT, 255, cycles allowed between grant and first source valid.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_arp_req  in  1  ARP has a payload pending; held until grant
- i_arp_len  in  16  ARP payload length in bytes; stable while req
- o_arp_grant  out  1  one-cycle grant pulse to ARP
- i_arp_data  in  8  ARP payload byte
- i_arp_last  in  1  last ARP byte
- i_arp_valid  in  1  ARP byte valid
- i_ip_req, i_ip_len, o_ip_grant, i_ip_data, i_ip_last, i_ip_valid: same as the ARP ports, for IP
- o_send_type  out  16  EtherType to framer
- o_send_data  out  8  payload byte to framer
- o_send_len  out  16  payload length to framer
- o_send_last  out  1  last payload byte
- o_send_valid  out  1  payload byte valid
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset: every output is 0. State = IDLE. Selected source = ARP. Counters cleared. Reset mid-frame drops the frame immediately; no tail is emitted.
- State IDLE: if any req is high, latch the winner's len and type, pulse that grant for one cycle, and go to WAIT. Fixed priority: ARP beats IP when both request.
- State WAIT: count cycles. On the selected source's first valid, go to XFER. If the count reaches P_GRANT_TIMEOUT with no valid, pulse o_err and go to GAP.
- State XFER: each selected valid byte is forwarded with exactly 1 cycle of latency (registered outputs). A byte counter increments per byte.
  - Last byte with counter+1 == len: forward it with o_send_last, then go to GAP.
  - Last byte with a count mismatch: forward it, pulse o_err, go to GAP.
  - Valid drops before last: forward nothing on that cycle, pulse o_err, go to GAP.
  - The framer needs contiguous valid, so sources must stream without holes.
- State GAP: count P_GAP_CYCLES, then go to IDLE. A req arriving during GAP is held, not granted, until IDLE.
- o_send_type and o_send_len are valid from the first o_send_valid through the end of GAP. They are 0 in IDLE.
- The non-selected source's valid and data are ignored in all states.
- len == 0 at grant: pulse o_err and go straight to GAP; no grant is issued.
- Counters are 16 bit. A frame longer than 65535 bytes is undefined usage.

Optional Feature:
- Macro MAC_TX_ARB_RR_EN.
- Defined: round-robin arbitration. When both sources request in IDLE, the source not served last wins. The last-served flag resets to IP, so ARP wins the first tie.
- Undefined: fixed priority, ARP always wins a tie.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/XFER/GAP), EtherType constants 0x0806/0x0800, default gap and timeout constants.
- One sub-module: mac_tx_gap_timer, a loadable down-counter with a done flag. It is reused for the WAIT timeout and the GAP hold-off.

Test Plan:
- ARP req with len=28, 28 contiguous bytes 0x01..0x1C, last on byte 28 -> one grant pulse; o_send_valid high 28 cycles, 1 cycle behind input; o_send_type=0x0806; o_send_len=28; o_send_last on 0x1C; o_busy falls 48 cycles after last.
- ARP and IP req in the same cycle -> ARP granted. IP granted exactly P_GAP_CYCLES+1 cycles after ARP's last. With MAC_TX_ARB_RR_EN, a second simultaneous tie grants IP first.
- IP len=46 but last on byte 40 -> 40 bytes forwarded, o_err pulses once, GAP entered, no o_send_last mismatch hang.
- Grant issued, source never asserts valid -> o_err after 255 cycles, then GAP, then IDLE; a pending IP req is granted afterwards.
- IP valid drops at byte 10 of 46 -> o_err pulse, forwarding stops, GAP entered, later IP bytes ignored.
- i_rst_n low mid-XFER -> all outputs 0 immediately; after release, a fresh ARP req is granted normally.

Source files
------------

// File: rtl/mac_tx_arbiter_pkg.sv
// mac_tx_arbiter_pkg: shared state encoding, EtherType constants and default
// timing constants for the MAC transmit arbiter and its gap timer.
package mac_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic [15:0] ARP_ETHERTYPE     = 16'h0806;
    localparam logic [15:0] IP_ETHERTYPE      = 16'h0800;
    localparam int          GAP_CYCLES_DEF    = 48;
    localparam int          GRANT_TIMEOUT_DEF = 255;

    // The gap timer flags done once it has counted down to zero, so a wait of
    // N cycles is loaded as N-1.
    function automatic logic [15:0] timerLoadValue(input int cycles);
        return (cycles > 0) ? 16'(cycles - 1) : 16'd0;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// mac_tx_arbiter_if: request/grant/payload signals of the ARP and IP sources
// plus the send stream towards the framer. The master modport is the arbiter,
// the slave modport is the environment (sources and framer).
interface mac_tx_arbiter_if;

    logic        i_arp_req;
    logic [15:0] i_arp_len;
    logic        o_arp_grant;
    logic [7:0]  i_arp_data;
    logic        i_arp_last;
    logic        i_arp_valid;

    logic        i_ip_req;
    logic [15:0] i_ip_len;
    logic        o_ip_grant;
    logic [7:0]  i_ip_data;
    logic        i_ip_last;
    logic        i_ip_valid;

    logic [15:0] o_send_type;
    logic [7:0]  o_send_data;
    logic [15:0] o_send_len;
    logic        o_send_last;
    logic        o_send_valid;
    logic        o_busy;
    logic        o_err;

    modport master (
        input  i_arp_req, i_arp_len, i_arp_data, i_arp_last, i_arp_valid,
        input  i_ip_req, i_ip_len, i_ip_data, i_ip_last, i_ip_valid,
        output o_arp_grant, o_ip_grant,
        output o_send_type, o_send_data, o_send_len, o_send_last, o_send_valid,
        output o_busy, o_err
    );

    modport slave (
        output i_arp_req, i_arp_len, i_arp_data, i_arp_last, i_arp_valid,
        output i_ip_req, i_ip_len, i_ip_data, i_ip_last, i_ip_valid,
        input  o_arp_grant, o_ip_grant,
        input  o_send_type, o_send_data, o_send_len, o_send_last, o_send_valid,
        input  o_busy, o_err
    );

endinterface

// File: rtl/mac_tx_gap_timer.sv
// mac_tx_gap_timer: loadable 16-bit down-counter with a done flag. Used both
// for the grant timeout and for the post-frame hold-off.
module mac_tx_gap_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        load_i,
    input  logic [15:0] value_i,
    output logic        done_o
);

    logic [15:0] count_q;

    // Load takes priority; otherwise count down and stick at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != 16'd0) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign done_o = (count_q == 16'd0);

endmodule

// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: grants one of two payload sources (ARP, IP) at a time,
// forwards its bytes to the MAC framer with one cycle of latency, and holds
// off the next grant until the framer has emitted header, CRC and gap.
// Optional build macro MAC_TX_ARB_RR_EN selects round-robin tie breaking;
// without it ARP always wins a tie.
module mac_tx_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter logic [15:0] P_ARP_TYPE      = ARP_ETHERTYPE,
    parameter logic [15:0] P_IP_TYPE       = IP_ETHERTYPE,
    parameter int          P_GAP_CYCLES    = GAP_CYCLES_DEF,
    parameter int          P_GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
    input logic              i_clk,
    input logic              i_rst_n,
    mac_tx_arbiter_if.master bus
);

    localparam logic [15:0] GAP_LOAD     = timerLoadValue(P_GAP_CYCLES);
    localparam logic [15:0] TIMEOUT_LOAD = timerLoadValue(P_GRANT_TIMEOUT);

    arb_state_t  state_q, state_d;
    logic        selIp_q, selIp_d;
    logic [15:0] type_q, type_d;
    logic [15:0] len_q, len_d;
    logic [15:0] byteCnt_q, byteCnt_d;
    logic [7:0]  sendData_q, sendData_d;
    logic        sendLast_q, sendLast_d;
    logic        sendValid_q, sendValid_d;
    logic        err_q, err_d;
    logic        arpGrant_q, arpGrant_d;
    logic        ipGrant_q, ipGrant_d;

    logic        pickIp;
    logic        selValid;
    logic        selLast;
    logic [7:0]  selData;
    logic        timerLoad;
    logic [15:0] timerValue;
    logic        timerDone;

`ifdef MAC_TX_ARB_RR_EN
    logic        lastIp_q, lastIp_d;
`endif

    assign selValid = selIp_q ? bus.i_ip_valid : bus.i_arp_valid;
    assign selLast  = selIp_q ? bus.i_ip_last  : bus.i_arp_last;
    assign selData  = selIp_q ? bus.i_ip_data  : bus.i_arp_data;

    mac_tx_gap_timer u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load_i  (timerLoad),
        .value_i (timerValue),
        .done_o  (timerDone)
    );

    // Next-state logic: arbitration in IDLE, byte forwarding and protocol
    // checks in WAIT/XFER, and the hold-off countdown in GAP.
    always_comb begin
        state_d     = state_q;
        selIp_d     = selIp_q;
        type_d      = type_q;
        len_d       = len_q;
        byteCnt_d   = byteCnt_q;
        sendData_d  = '0;
        sendLast_d  = 1'b0;
        sendValid_d = 1'b0;
        err_d       = 1'b0;
        arpGrant_d  = 1'b0;
        ipGrant_d   = 1'b0;
        pickIp      = 1'b0;
        timerLoad   = 1'b0;
        timerValue  = '0;
`ifdef MAC_TX_ARB_RR_EN
        lastIp_d    = lastIp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_arp_req || bus.i_ip_req) begin
`ifdef MAC_TX_ARB_RR_EN
                    pickIp = bus.i_ip_req && (!bus.i_arp_req || !lastIp_q);
`else
                    pickIp = !bus.i_arp_req;
`endif
                    selIp_d   = pickIp;
                    type_d    = pickIp ? P_IP_TYPE : P_ARP_TYPE;
                    len_d     = pickIp ? bus.i_ip_len : bus.i_arp_len;
                    byteCnt_d = '0;
                    timerLoad = 1'b1;
                    if (len_d == 16'd0) begin
                        err_d      = 1'b1;
                        state_d    = ST_GAP;
                        timerValue = GAP_LOAD;
                    end else begin
                        arpGrant_d = !pickIp;
                        ipGrant_d  = pickIp;
                        state_d    = ST_WAIT;
                        timerValue = TIMEOUT_LOAD;
`ifdef MAC_TX_ARB_RR_EN
                        lastIp_d   = pickIp;
`endif
                    end
                end
            end
            ST_WAIT, ST_XFER: begin
                if (selValid) begin
                    sendValid_d = 1'b1;
                    sendData_d  = selData;
                    byteCnt_d   = byteCnt_q + 16'd1;
                    state_d     = ST_XFER;
                    if (selLast) begin
                        sendLast_d = 1'b1;
                        err_d      = (byteCnt_d != len_q);
                        state_d    = ST_GAP;
                        timerLoad  = 1'b1;
                        timerValue = GAP_LOAD;
                    end
                end else if ((state_q == ST_XFER) || timerDone) begin
                    err_d      = 1'b1;
                    state_d    = ST_GAP;
                    timerLoad  = 1'b1;
                    timerValue = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (timerDone) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            selIp_q     <= 1'b0;
            type_q      <= '0;
            len_q       <= '0;
            byteCnt_q   <= '0;
            sendData_q  <= '0;
            sendLast_q  <= 1'b0;
            sendValid_q <= 1'b0;
            err_q       <= 1'b0;
            arpGrant_q  <= 1'b0;
            ipGrant_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            selIp_q     <= selIp_d;
            type_q      <= type_d;
            len_q       <= len_d;
            byteCnt_q   <= byteCnt_d;
            sendData_q  <= sendData_d;
            sendLast_q  <= sendLast_d;
            sendValid_q <= sendValid_d;
            err_q       <= err_d;
            arpGrant_q  <= arpGrant_d;
            ipGrant_q   <= ipGrant_d;
        end
    end

`ifdef MAC_TX_ARB_RR_EN
    // Last-served flag starts on IP so that ARP wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lastIp_q <= 1'b1;
        end else begin
            lastIp_q <= lastIp_d;
        end
    end
`endif

    assign bus.o_arp_grant  = arpGrant_q;
    assign bus.o_ip_grant   = ipGrant_q;
    assign bus.o_send_data  = sendData_q;
    assign bus.o_send_last  = sendLast_q;
    assign bus.o_send_valid = sendValid_q;
    assign bus.o_err        = err_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_send_type  = (state_q != ST_IDLE) ? type_q : 16'd0;
    assign bus.o_send_len   = (state_q != ST_IDLE) ? len_q  : 16'd0;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: table-driven transactions plus hand-written tie, timeout
// and mid-frame reset sequences. Forwarded bytes are checked by a scoreboard
// queue filled as source bytes are driven.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;

    typedef struct {
        logic        srcIp;
        logic [15:0] len;
        int          nBytes;
        logic        lastAtEnd;
        logic        hole;
        int          expErr;
        logic [15:0] expType;
    } vec_t;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [15:0] typ;
        logic [15:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    mac_tx_arbiter_if bus();

    mac_tx_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    exp_t sbQ[$];
    exp_t mon;
    vec_t vecs[8];
    vec_t rec;
    int   checks = 0;
    int   errors = 0;
    int   errSeen = 0;
    int   arpGrants = 0;
    int   ipGrants = 0;
    int   n;
    logic secondIp;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " send_valid"}, int'(bus.o_send_valid), 0);
        checkOutput({tag, " send_last"},  int'(bus.o_send_last), 0);
        checkOutput({tag, " send_data"},  int'(bus.o_send_data), 0);
        checkOutput({tag, " send_type"},  int'(bus.o_send_type), 0);
        checkOutput({tag, " send_len"},   int'(bus.o_send_len), 0);
        checkOutput({tag, " busy"},       int'(bus.o_busy), 0);
        checkOutput({tag, " err"},        int'(bus.o_err), 0);
        checkOutput({tag, " arp_grant"},  int'(bus.o_arp_grant), 0);
        checkOutput({tag, " ip_grant"},   int'(bus.o_ip_grant), 0);
    endtask

    // Drive one byte on the chosen source and noise on the other one.
    task automatic driveByte(input logic src, input logic v, input logic [7:0] d, input logic l);
        if (src) begin
            bus.i_ip_valid  = v;
            bus.i_ip_data   = d;
            bus.i_ip_last   = l;
            bus.i_arp_valid = v;
            bus.i_arp_data  = 8'($urandom);
            bus.i_arp_last  = v & 1'($urandom);
        end else begin
            bus.i_arp_valid = v;
            bus.i_arp_data  = d;
            bus.i_arp_last  = l;
            bus.i_ip_valid  = v;
            bus.i_ip_data   = 8'($urandom);
            bus.i_ip_last   = v & 1'($urandom);
        end
    endtask

    task automatic waitGrant(input logic src, output int cnt);
        cnt = 0;
        while (!(src ? bus.o_ip_grant : bus.o_arp_grant) && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    task automatic waitIdle(output int cnt);
        cnt = 0;
        while (bus.o_busy && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    task automatic streamBytes(input logic src, input int nBytes, input logic lastAtEnd,
                               input logic [15:0] len, input logic [15:0] typ);
        logic [7:0] d;
        logic       l;
        for (int i = 1; i <= nBytes; i++) begin
            d = (src ? 8'h80 : 8'h00) + 8'(i);
            l = lastAtEnd && (i == nBytes);
            driveByte(src, 1'b1, d, l);
            sbQ.push_back('{d, l, typ, len});
            tick();
        end
        driveByte(src, 1'b0, 8'h00, 1'b0);
        if (nBytes > 0) begin
            checkOutput("last flag one cycle after last byte", int'(bus.o_send_last), int'(lastAtEnd));
        end
    endtask

    // Run one table record: request, grant, stream, hold-off and totals.
    task automatic applyStimulus(input vec_t v, input int idx);
        int errBase;
        int grantBase;
        int cnt;
        errBase   = errSeen;
        grantBase = arpGrants + ipGrants;
        if (v.srcIp) begin
            bus.i_ip_req = 1'b1;
            bus.i_ip_len = v.len;
        end else begin
            bus.i_arp_req = 1'b1;
            bus.i_arp_len = v.len;
        end
        if (v.len == 16'd0) begin
            tick();
            bus.i_arp_req = 1'b0;
            bus.i_ip_req  = 1'b0;
            waitIdle(cnt);
            checkOutput($sformatf("vec%0d zero-len gap cycles", idx), cnt, 48);
        end else begin
            waitGrant(v.srcIp, cnt);
            checkOutput($sformatf("vec%0d grant latency", idx), cnt, 1);
            bus.i_arp_req = 1'b0;
            bus.i_ip_req  = 1'b0;
            streamBytes(v.srcIp, v.nBytes, v.lastAtEnd, v.len, v.expType);
            if (v.hole) begin
                tick();
                for (int j = 0; j < 3; j++) begin
                    driveByte(v.srcIp, 1'b1, 8'hEE, 1'b0);
                    tick();
                end
                driveByte(v.srcIp, 1'b0, 8'h00, 1'b0);
                waitIdle(cnt);
                checkOutput($sformatf("vec%0d gap after hole", idx), cnt + 4, 49);
            end else begin
                waitIdle(cnt);
                checkOutput($sformatf("vec%0d gap after last", idx), cnt, 48);
            end
        end
        tick();
        checkOutput($sformatf("vec%0d err pulses", idx), errSeen - errBase, v.expErr);
        checkOutput($sformatf("vec%0d grants", idx), arpGrants + ipGrants - grantBase,
                    (v.len == 16'd0) ? 0 : 1);
        checkOutput($sformatf("vec%0d scoreboard drained", idx), sbQ.size(), 0);
        checkOutput($sformatf("vec%0d idle type", idx), int'(bus.o_send_type), 0);
        checkOutput($sformatf("vec%0d idle len", idx), int'(bus.o_send_len), 0);
    endtask

    // Output monitor: counts pulses and compares every forwarded byte with the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_err)       errSeen++;
            if (bus.o_arp_grant) arpGrants++;
            if (bus.o_ip_grant)  ipGrants++;
            if (bus.o_send_valid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("scoreboard underflow on unexpected byte", sbQ.size(), 1);
                end else begin
                    mon = sbQ.pop_front();
                    checkOutput("send_data", int'(bus.o_send_data), int'(mon.data));
                    checkOutput("send_last", int'(bus.o_send_last), int'(mon.last));
                    checkOutput("send_type", int'(bus.o_send_type), int'(mon.typ));
                    checkOutput("send_len",  int'(bus.o_send_len),  int'(mon.len));
                end
            end
        end
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        rst_n = 1'b0;
        bus.i_arp_req = 1'b0; bus.i_arp_len = '0; bus.i_arp_data = '0;
        bus.i_arp_last = 1'b0; bus.i_arp_valid = 1'b0;
        bus.i_ip_req = 1'b0; bus.i_ip_len = '0; bus.i_ip_data = '0;
        bus.i_ip_last = 1'b0; bus.i_ip_valid = 1'b0;

        vecs[0] = '{1'b0, 16'd28, 28, 1'b1, 1'b0, 0, 16'h0806};
        vecs[1] = '{1'b1, 16'd46, 40, 1'b1, 1'b0, 1, 16'h0800};
        vecs[2] = '{1'b1, 16'd46,  9, 1'b0, 1'b1, 1, 16'h0800};
        vecs[3] = '{1'b0, 16'd1,   1, 1'b1, 1'b0, 0, 16'h0806};
        vecs[4] = '{1'b1, 16'd0,   0, 1'b0, 1'b0, 1, 16'h0800};
        vecs[5] = '{1'b1, 16'd5,   5, 1'b1, 1'b0, 0, 16'h0800};
        vecs[6] = '{1'b0, 16'd3,   5, 1'b1, 1'b0, 1, 16'h0806};
        vecs[7] = '{1'b0, 16'd3,   3, 1'b1, 1'b0, 0, 16'h0806};

        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] tie: ARP and IP request together");
        bus.i_arp_req = 1'b1; bus.i_arp_len = 16'd4;
        bus.i_ip_req  = 1'b1; bus.i_ip_len  = 16'd3;
        waitGrant(1'b0, n);
        checkOutput("tie1 ARP grant latency", n, 1);
        checkOutput("tie1 IP not granted", int'(bus.o_ip_grant), 0);
        bus.i_arp_req = 1'b0;
        streamBytes(1'b0, 4, 1'b1, 16'd4, 16'h0806);
        bus.i_arp_req = 1'b1; bus.i_arp_len = 16'd2;
`ifdef MAC_TX_ARB_RR_EN
        secondIp = 1'b1;
`else
        secondIp = 1'b0;
`endif
        waitGrant(secondIp, n);
        checkOutput("tie2 grant after gap", n, 49);
        checkOutput("tie2 loser not granted",
                    int'(secondIp ? bus.o_arp_grant : bus.o_ip_grant), 0);
        if (secondIp) bus.i_ip_req = 1'b0; else bus.i_arp_req = 1'b0;
        streamBytes(secondIp, secondIp ? 3 : 2, 1'b1, secondIp ? 16'd3 : 16'd2,
                    secondIp ? 16'h0800 : 16'h0806);
        waitGrant(!secondIp, n);
        checkOutput("tie2 other source after gap", n, 49);
        bus.i_arp_req = 1'b0;
        bus.i_ip_req  = 1'b0;
        streamBytes(!secondIp, secondIp ? 2 : 3, 1'b1, secondIp ? 16'd2 : 16'd3,
                    secondIp ? 16'h0806 : 16'h0800);
        waitIdle(n);
        checkOutput("tie sequence idle", n, 48);

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] grant timeout with IP pending");
        begin
            int errBase;
            errBase = errSeen;
            bus.i_arp_req = 1'b1; bus.i_arp_len = 16'd10;
            waitGrant(1'b0, n);
            checkOutput("timeout grant latency", n, 1);
            bus.i_arp_req = 1'b0;
            bus.i_ip_req = 1'b1; bus.i_ip_len = 16'd2;
            n = 0;
            while (!bus.o_err && n < 400) begin
                tick();
                n++;
            end
            checkOutput("timeout err delay", n, 255);
            waitGrant(1'b1, n);
            checkOutput("timeout IP grant after gap", n, 49);
            bus.i_ip_req = 1'b0;
            streamBytes(1'b1, 2, 1'b1, 16'd2, 16'h0800);
            waitIdle(n);
            tick();
            checkOutput("timeout err pulses", errSeen - errBase, 1);
        end

        $display("[TB] reset in the middle of a frame");
        bus.i_arp_req = 1'b1; bus.i_arp_len = 16'd20;
        waitGrant(1'b0, n);
        checkOutput("reset-test grant latency", n, 1);
        bus.i_arp_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            driveByte(1'b0, 1'b1, 8'(i), 1'b0);
            sbQ.push_back('{8'(i), 1'b0, 16'h0806, 16'd20});
            tick();
        end
        checkOutput("pre-reset send_valid", int'(bus.o_send_valid), 1);
        rst_n = 1'b0;
        #1;
        sbQ.delete();
        checkReset("mid-frame reset");
        driveByte(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rec = vecs[7];
        applyStimulus(rec, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
